rom_scan_ctrl: RTL and testbench

- Sequencer for the 28-entry lookup ROM (5-bit select, 6-bit word).
- Drives the ROM select, captures each word, and streams it out on a valid/ready interface over a programmable index window [first_idx, last_idx].
- Supports single-pass and continuous-loop scans.
- Sits between the ROM and any downstream consumer; the ROM itself stays purely combinational and external.

---
 rtl/rom_scan_if.sv | 31 +++
 rtl/rom_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_rom_scan_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rom_scan_if.sv
// Bundle between the ROM scan sequencer and its environment: scan control,
// ROM select/data and the valid/ready output stream.
interface rom_scan_if #(
    parameter int SIZE   = 6,
    parameter int ADDR_W = 5
);
    logic              start;
    logic              abort;
    logic              loop_en;
    logic [ADDR_W-1:0] first_idx;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] rom_sel;
    logic [SIZE-1:0]   rom_data;
    logic [SIZE-1:0]   out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        pass_cnt;

    modport slave (
        input  start, abort, loop_en, first_idx, last_idx, rom_data, out_ready,
        output rom_sel, out_data, out_valid, busy, done, err, pass_cnt
    );

    modport master (
        output start, abort, loop_en, first_idx, last_idx, rom_data, out_ready,
        input  rom_sel, out_data, out_valid, busy, done, err, pass_cnt
    );
endinterface

// File: rtl/rom_scan_ctrl.sv
// Walks an external combinational ROM over [first_idx, last_idx] and streams
// each word on a valid/ready port; single-pass or continuous loop.
module rom_scan_ctrl #(
    parameter int SIZE   = 6,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    rom_scan_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] sel_q, sel_n, first_q, first_n, last_q, last_n;
    logic              loop_q, loop_n;
    logic [SIZE-1:0]   data_q, data_n;
    logic              valid_q, valid_n, busy_q, busy_n, done_q, done_n, err_q, err_n;
    logic [7:0]        pass_q, pass_n;
    logic              legal;

    assign legal = (bus.first_idx <= bus.last_idx) && (int'(bus.last_idx) < DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pass_q  <= '0;
        end else begin
            state   <= state_n;
            sel_q   <= sel_n;
            first_q <= first_n;
            last_q  <= last_n;
            loop_q  <= loop_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
            pass_q  <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        first_n = first_q;
        last_n  = last_q;
        loop_n  = loop_q;
        data_n  = data_q;
        valid_n = valid_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        pass_n  = pass_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (legal) begin
                        first_n = bus.first_idx;
                        last_n  = bus.last_idx;
                        loop_n  = bus.loop_en;
                        sel_n   = bus.first_idx;
                        pass_n  = '0;
                        state_n = FETCH;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            FETCH: begin
                data_n  = bus.rom_data;
                valid_n = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                if (valid_q && bus.out_ready) begin
                    valid_n = 1'b0;
                    if (sel_q != last_q) begin
                        sel_n   = sel_q + 1'b1;
                        state_n = FETCH;
                    end else begin
                        pass_n = pass_q + 8'd1;
                        if (loop_q) begin
                            sel_n   = first_q;
                            state_n = FETCH;
                        end else begin
                            done_n  = 1'b1;
                            state_n = DONE;
                        end
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // abort wins over a same-cycle handshake: index and pass count stay put
        if (bus.abort && state != IDLE) begin
            state_n = IDLE;
            sel_n   = sel_q;
            pass_n  = pass_q;
            valid_n = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_comb busy_n = (state_n == FETCH) || (state_n == SEND);

    assign bus.rom_sel   = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.pass_cnt  = pass_q;
endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl with a behavioural 28-entry ROM.
module tb_rom_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;
    logic [5:0] rom [0:27];
    logic [5:0] exp0 [0:6];

    rom_scan_if #(.SIZE(6), .ADDR_W(5)) bus ();

    rom_scan_ctrl #(.SIZE(6), .ADDR_W(5), .DEPTH(28)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.rom_data = 6'd0;
        if (bus.rom_sel < 5'd28) bus.rom_data = rom[bus.rom_sel];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rom = '{6'd1, 6'd3, 6'd4, 6'd8, 6'd10, 6'd13, 6'd15, 6'd17, 6'd19, 6'd22,
                6'd24, 6'd26, 6'd29, 6'd31, 6'd33, 6'd36, 6'd38, 6'd40, 6'd42, 6'd45,
                6'd47, 6'd49, 6'd51, 6'd54, 6'd56, 6'd58, 6'd60, 6'd63};
        exp0 = '{6'd1, 6'd3, 6'd4, 6'd8, 6'd10, 6'd13, 6'd15};
        bus.start = 0; bus.abort = 0; bus.loop_en = 0;
        bus.first_idx = 0; bus.last_idx = 0; bus.out_ready = 0;

        // reset state
        #2;
        chk("rst_rom_sel", 32'(bus.rom_sel), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_pass_cnt", 32'(bus.pass_cnt), 0);
        #1 rst_n = 1'b1;

        // single pass 0..6
        tick();
        bus.first_idx = 0; bus.last_idx = 6; bus.loop_en = 0; bus.out_ready = 1; bus.start = 1;
        tick();
        bus.start = 0;
        chk("sp_busy", 32'(bus.busy), 1);
        chk("sp_fetch_valid", 32'(bus.out_valid), 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("sp_valid", 32'(bus.out_valid), 1);
            chk("sp_data", 32'(bus.out_data), 32'(exp0[i]));
            tick();
            chk("sp_gap", 32'(bus.out_valid), 0);
        end
        chk("sp_done", 32'(bus.done), 1);
        chk("sp_pass", 32'(bus.pass_cnt), 1);
        chk("sp_busy_end", 32'(bus.busy), 0);
        chk("sp_sel_last", 32'(bus.rom_sel), 6);
        tick();
        chk("sp_done_pulse", 32'(bus.done), 0);

        // backpressure 12..14
        bus.first_idx = 12; bus.last_idx = 14; bus.start = 1;
        tick();
        bus.start = 0;
        tick();
        chk("bp_d0", 32'(bus.out_data), 29);
        tick();
        bus.out_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_stall_valid", 32'(bus.out_valid), 1);
            chk("bp_stall_data", 32'(bus.out_data), 31);
            tick();
        end
        chk("bp_stall_end", 32'(bus.out_data), 31);
        bus.out_ready = 1;
        tick();
        chk("bp_after_valid", 32'(bus.out_valid), 0);
        chk("bp_after_sel", 32'(bus.rom_sel), 14);
        tick();
        chk("bp_d2", 32'(bus.out_data), 33);
        tick();
        chk("bp_done", 32'(bus.done), 1);
        chk("bp_pass", 32'(bus.pass_cnt), 1);
        tick();

        // loop on single word 27
        bus.first_idx = 27; bus.last_idx = 27; bus.loop_en = 1; bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("lp_valid", 32'(bus.out_valid), 1);
            chk("lp_data", 32'(bus.out_data), 63);
            tick();
            chk("lp_pass", 32'(bus.pass_cnt), 32'(k + 1));
            chk("lp_nodone", 32'(bus.done), 0);
        end
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("lp_abort_valid", 32'(bus.out_valid), 0);
        chk("lp_abort_busy", 32'(bus.busy), 0);
        chk("lp_abort_pass", 32'(bus.pass_cnt), 4);

        // illegal windows
        bus.first_idx = 10; bus.last_idx = 5; bus.loop_en = 0; bus.start = 1;
        tick();
        bus.start = 0;
        chk("il1_err", 32'(bus.err), 1);
        chk("il1_busy", 32'(bus.busy), 0);
        chk("il1_sel", 32'(bus.rom_sel), 27);
        chk("il1_pass", 32'(bus.pass_cnt), 4);
        tick();
        chk("il1_err_pulse", 32'(bus.err), 0);
        bus.first_idx = 0; bus.last_idx = 28; bus.start = 1;
        tick();
        bus.start = 0;
        chk("il2_err", 32'(bus.err), 1);
        chk("il2_busy", 32'(bus.busy), 0);
        tick();

        // abort coinciding with handshake of index 3
        bus.first_idx = 0; bus.last_idx = 6; bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
        end
        tick();
        chk("ab_data", 32'(bus.out_data), 8);
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("ab_busy", 32'(bus.busy), 0);
        chk("ab_valid", 32'(bus.out_valid), 0);
        chk("ab_sel", 32'(bus.rom_sel), 3);
        chk("ab_pass", 32'(bus.pass_cnt), 0);
        chk("ab_done", 32'(bus.done), 0);
        tick();
        chk("ab_done_next", 32'(bus.done), 0);

        // start+abort together in IDLE: start wins
        bus.first_idx = 12; bus.last_idx = 14; bus.start = 1; bus.abort = 1;
        tick();
        bus.start = 0; bus.abort = 0;
        chk("sa_busy", 32'(bus.busy), 1);
        chk("sa_sel", 32'(bus.rom_sel), 12);

        // async reset mid-SEND
        tick();
        bus.out_ready = 0;
        chk("rs_pre_valid", 32'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_valid", 32'(bus.out_valid), 0);
        chk("rs_busy", 32'(bus.busy), 0);
        chk("rs_sel", 32'(bus.rom_sel), 0);
        chk("rs_data", 32'(bus.out_data), 0);
        chk("rs_pass", 32'(bus.pass_cnt), 0);
        #2 rst_n = 1'b1;
        tick();
        chk("rs_idle_busy", 32'(bus.busy), 0);
        chk("rs_idle_done", 32'(bus.done), 0);
        chk("rs_idle_valid", 32'(bus.out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
